// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem requests and a small
// prefetch queue presenting {pc, instruction} to the ID stage.
module fetch_unit #(
  parameter int unsigned         WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter int unsigned         QDEPTH   = 2,
  parameter int unsigned         PC_INC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                if_valid,
  output logic [WORD_LEN-1:0] if_pc,
  output logic [WORD_LEN-1:0] if_instruction
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic [WORD_LEN-1:0] pc_mem_q    [QDEPTH];
  logic [WORD_LEN-1:0] instr_mem_q [QDEPTH];
  logic                push, pop;

  always_comb begin
    pop  = (count_q != '0) && !freeze && !br_taken;
    push = (state_q == StWait) && imem_ack && !br_taken;

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;

    if (br_taken) begin
      // Flush: an empty queue is any position with head == tail.
      head_d     = tail_q;
      count_d    = '0;
      fetch_pc_d = br_target;
    end else begin
      if (pop)  head_d = head_q + PtrW'(1);
      if (push) tail_d = tail_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (push) fetch_pc_d = fetch_pc_q + WORD_LEN'(PC_INC);
    end

    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (count_d < CntW'(QDEPTH)) state_d = StWait;
      end
      StWait: begin
        if (imem_ack) begin
          state_d = (!br_taken && (count_d < CntW'(QDEPTH))) ? StWait : StIdle;
        end else if (br_taken) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The address only moves when no transaction is in flight, so a redirect
    // in DROP leaves the stale request's address untouched until its ack.
    addr_d = ((state_q == StIdle) || imem_ack) ? fetch_pc_d : addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_req       = (state_q != StIdle);
    imem_addr      = addr_q;
    if_valid       = (count_q != '0);
    if_pc          = if_valid ? pc_mem_q[head_q] : '0;
    if_instruction = if_valid ? instr_mem_q[head_q] : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a random-latency memory model drives the DUT while a
// monitor checks the consumed {pc, instruction} stream against a program-order model.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc  = 32'h0;
  localparam logic [31:0] InstrOfs = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  always #5 clk = ~clk;

  // Driver-owned control flags read by the monitor.
  int   mem_lat    = 1;     // 0 = random 1..4 cycles
  bit   spur_ack   = 1'b0;  // random acks while no request is outstanding
  bit   must_valid = 1'b0;
  bit   lat_chk    = 1'b0;
  bit   dir_freeze = 1'b0;
  bit   done       = 1'b0;
  bit   mem_busy   = 1'b0;
  int   mem_left   = 0;

  task automatic step(input logic fr, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    freeze    = fr;
    br_taken  = br;
    br_target = tgt;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
      end
      mem_left = mem_left - 1;
      if (mem_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = InstrOfs + imem_addr;
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      mem_busy   = 1'b0;
      imem_ack   = spur_ack && ($urandom_range(3, 0) == 0);
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    freeze   = 1'b0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    mem_busy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Sequential stream with zero-wait memory.
    mem_lat = 1;
    lat_chk = 1'b1;
    do_reset(3);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    lat_chk    = 1'b0;
    must_valid = 1'b1;
    repeat (20) step(1'b0, 1'b0, '0);
    // Freeze: outputs held, queue fills, request drops, then no gaps.
    dir_freeze = 1'b1;
    repeat (5) step(1'b1, 1'b0, '0);
    dir_freeze = 1'b0;
    repeat (10) step(1'b0, 1'b0, '0);
    must_valid = 1'b0;
    // Redirect while a slow request is in flight.
    mem_lat = 3;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0);
      if (imem_req && !imem_ack) begin
        br_taken  = 1'b1;
        br_target = 32'h100;
        break;
      end
    end
    repeat (15) step(1'b0, 1'b0, '0);
    // Redirect in the same cycle as an ack.
    mem_lat = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0);
      if (imem_ack) begin
        br_taken  = 1'b1;
        br_target = 32'h200;
        break;
      end
    end
    repeat (10) step(1'b0, 1'b0, '0);
    // Slow memory stream.
    mem_lat = 3;
    repeat (30) step(1'b0, 1'b0, '0);
    // Asynchronous reset with the queue filled and a request pending.
    mem_lat = 2;
    repeat (6) step(1'b1, 1'b0, '0);
    do_reset(2);
    mem_lat = 1;
    repeat (10) step(1'b0, 1'b0, '0);
    // Random traffic.
    mem_lat  = 0;
    spur_ack = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic        fr;
      logic        br;
      logic [31:0] tgt;
      fr  = ($urandom_range(99, 0) < 30);
      br  = ($urandom_range(99, 0) < 4);
      tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(999, 0) < 3) do_reset(1);
      else step(fr, br, tgt);
    end
    spur_ack = 1'b0;
    repeat (3) step(1'b0, 1'b0, '0);
    done = 1'b1;
  end

  // Monitor / scoreboard: exp_q holds the next pc the ID stage must consume.
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          rel_cnt = 0;
  int          frz_run = 0;
  logic [31:0] exp_q [$];
  logic        prev_br, prev_frz_hold, prev_req, prev_ack;
  logic [31:0] prev_pc, prev_instr, prev_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (consumed < 500) begin
        errors++;
        $display("FAIL progress: consumed %0d expected at least 500", consumed);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (rst) begin
      chk("reset_imem_req", {31'b0, imem_req}, 32'h0);
      chk("reset_imem_addr", imem_addr, ResetPc);
      chk("reset_if_valid", {31'b0, if_valid}, 32'h0);
      chk("reset_if_pc", if_pc, 32'h0);
      chk("reset_if_instr", if_instruction, 32'h0);
      exp_q.delete();
      exp_q.push_back(ResetPc);
      rel_cnt       = 0;
      frz_run       = 0;
      prev_br       = 1'b0;
      prev_frz_hold = 1'b0;
      prev_req      = 1'b0;
      prev_ack      = 1'b0;
    end else begin
      rel_cnt++;
      frz_run = freeze ? frz_run + 1 : 0;
      if (!if_valid) begin
        chk("idle_if_pc", if_pc, 32'h0);
        chk("idle_if_instr", if_instruction, 32'h0);
      end
      if (prev_br) chk("valid_after_branch", {31'b0, if_valid}, 32'h0);
      if (prev_frz_hold) begin
        chk("freeze_valid", {31'b0, if_valid}, 32'h1);
        chk("freeze_pc", if_pc, prev_pc);
        chk("freeze_instr", if_instruction, prev_instr);
      end
      if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
      if (lat_chk && rel_cnt == 2) chk("first_valid_early", {31'b0, if_valid}, 32'h0);
      if (lat_chk && rel_cnt == 3) chk("first_valid_latency", {31'b0, if_valid}, 32'h1);
      if (must_valid) chk("no_gap", {31'b0, if_valid}, 32'h1);
      if (dir_freeze && frz_run >= 3) chk("req_drop_when_full", {31'b0, imem_req}, 32'h0);
      if (if_valid && !freeze && !br_taken) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_nonempty", 32'h0, 32'h1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("stream_pc", if_pc, e);
          chk("stream_instr", if_instruction, InstrOfs + e);
          exp_q.push_back(e + 32'd4);
        end
        consumed++;
      end
      if (br_taken) begin
        exp_q.delete();
        exp_q.push_back(br_target);
      end
      prev_br       = br_taken;
      prev_frz_hold = freeze && if_valid && !br_taken;
      prev_pc       = if_pc;
      prev_instr    = if_instruction;
      prev_req      = imem_req;
      prev_ack      = imem_ack;
      prev_addr     = imem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
